edge_packer: RTL and testbench

Stream sink for the binarised Sobel output. Consumes the 8-bit edge pixel stream (0 = edge, 255 = background) with its one-cycle valid strobe and packs each pixel into one bit, 8 pixels per byte, MSB first, rows padded to a byte boundary. Bytes are buffered in a small FIFO and handed to the downstream byte transmitter (UART TX path) over a valid/ready handshake, with frame-end marking and overflow detection.

---
 rtl/edge_packer_pkg.sv | 17 +
 rtl/edge_packer_sync_fifo.sv | 69 ++++++
 rtl/edge_packer.sv | 108 ++++++++++
 tb/tb_edge_packer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_packer_pkg.sv
// Shared types and helpers for the edge-image bit packer.
// A FIFO entry carries the packed byte plus its end-of-frame marker.
package edge_packer_pkg;

  localparam int ENTRY_W = 9;

  // The Sobel stage emits 0 for edges and 255 for background,
  // so the MSB alone decides the bit.
  function automatic logic edge_bit(input logic [7:0] px);
    return ~px[7];
  endfunction

  function automatic int bytes_per_row(input int cols);
    return (cols + 7) / 8;
  endfunction

endpackage

// File: rtl/edge_packer_sync_fifo.sv
// Synchronous FIFO with a registered output stage that counts toward its capacity.
// rd_valid rises one cycle after the first write into an empty FIFO.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      mem_cnt_r;
  logic [AW:0]      occ_s;
  logic             take_s;
  logic             load_s;
  logic             wr_en_s;

  // Occupancy includes the output register, so full means DEPTH bytes held in total.
  always_comb begin
    occ_s   = mem_cnt_r + {{AW{1'b0}}, rd_valid};
    full    = (occ_s == (AW+1)'(DEPTH));
    empty   = (occ_s == (AW+1)'(0));
    take_s  = pop & rd_valid;
    load_s  = (mem_cnt_r != (AW+1)'(0)) & (~rd_valid | take_s);
    wr_en_s = push & (~full | take_s);
  end

  // Storage array; contents are meaningless until a pointer covers them.
  always_ff @(posedge sclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, fill count and output stage.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= AW'(0);
      rd_ptr_r  <= AW'(0);
      mem_cnt_r <= (AW+1)'(0);
      rd_data   <= WIDTH'(0);
      rd_valid  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      mem_cnt_r <= mem_cnt_r + (AW+1)'(wr_en_s) - (AW+1)'(load_s);
      if (load_s) begin
        rd_data  <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(1);
        rd_valid <= 1'b1;
      end else if (take_s) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_packer.sv
// Packs the binarised edge stream into bytes, MSB first, one padded byte group per row,
// and queues the bytes with an end-of-frame marker for the byte transmitter.
module edge_packer
  import edge_packer_pkg::*;
#(
  parameter int COLS       = 318,
  parameter int ROWS       = 718,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic [7:0] po_data,
  output logic       po_valid,
  input  logic       po_ready,
  output logic       po_last,
  output logic       frame_done,
  output logic       overflow
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]      col_cnt_r;
  logic [RW-1:0]      row_cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shreg_r;
  logic               overflow_r;
  logic               frame_done_r;

  logic               col_last_s;
  logic               row_last_s;
  logic               push_s;
  logic               last_s;
  logic               drop_s;
  logic [7:0]         byte_s;
  logic               fifo_full_s;
  logic               fifo_unused_empty_s;
  logic [ENTRY_W-1:0] fifo_rd_s;

  // Current byte including the pixel arriving this cycle; bits below it are still zero.
  always_comb begin
    col_last_s = (col_cnt_r == CW'(COLS - 1));
    row_last_s = (row_cnt_r == RW'(ROWS - 1));
    byte_s     = shreg_r;
    byte_s[3'd7 - bit_cnt_r] = edge_bit(pi_data);
    push_s     = pi_flag & ((bit_cnt_r == 3'd7) | col_last_s);
    last_s     = col_last_s & row_last_s;
    drop_s     = push_s & fifo_full_s & ~(po_valid & po_ready);
  end

  // Position counters and shift register; they advance even when a byte is dropped.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_r <= CW'(0);
      row_cnt_r <= RW'(0);
      bit_cnt_r <= 3'd0;
      shreg_r   <= 8'd0;
    end else if (pi_flag) begin
      if (push_s) begin
        shreg_r   <= 8'd0;
        bit_cnt_r <= 3'd0;
      end else begin
        shreg_r   <= byte_s;
        bit_cnt_r <= bit_cnt_r + 3'd1;
      end
      if (col_last_s) begin
        col_cnt_r <= CW'(0);
        row_cnt_r <= row_last_s ? RW'(0) : row_cnt_r + RW'(1);
      end else begin
        col_cnt_r <= col_cnt_r + CW'(1);
      end
    end
  end

  // Status flags: overflow is sticky until reset.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      overflow_r   <= overflow_r | drop_s;
      frame_done_r <= push_s & last_s;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .push     (push_s),
    .wr_data  ({last_s, byte_s}),
    .pop      (po_ready),
    .rd_data  (fifo_rd_s),
    .rd_valid (po_valid),
    .full     (fifo_full_s),
    .empty    (fifo_unused_empty_s)
  );

  assign po_data    = fifo_rd_s[7:0];
  assign po_last    = fifo_rd_s[8];
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_edge_packer.sv
// Directed bench for edge_packer: three differently sized instances, a per-instance
// reference packer feeding expected-byte queues, and a negedge monitor popping them.
module tb_edge_packer;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] pi_data_a, pi_data_b, pi_data_c;
  logic       pi_flag_a, pi_flag_b, pi_flag_c;
  logic       po_ready_a, po_ready_b, po_ready_c;
  logic [7:0] po_data_a, po_data_b, po_data_c;
  logic       po_valid_a, po_valid_b, po_valid_c;
  logic       po_last_a, po_last_b, po_last_c;
  logic       frame_done_a, frame_done_b, frame_done_c;
  logic       overflow_a, overflow_b, overflow_c;

  int n_cmp = 0;
  int n_fail = 0;

  int         cols_of [3] = '{16, 10, 318};
  int         rows_of [3] = '{2, 1, 4};
  int         m_col [3];
  int         m_row [3];
  int         m_bit [3];
  logic [7:0] m_sh [3];
  int         fd_cnt [3];
  int         n_out [3];
  bit         stall_prev [3];
  logic [8:0] stall_val [3];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] q2 [$];

  always #5 sclk = ~sclk;

  edge_packer #(.COLS(16), .ROWS(2), .FIFO_DEPTH(4)) u_dut_a (
    .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data_a), .pi_flag(pi_flag_a),
    .po_data(po_data_a), .po_valid(po_valid_a), .po_ready(po_ready_a),
    .po_last(po_last_a), .frame_done(frame_done_a), .overflow(overflow_a));

  edge_packer #(.COLS(10), .ROWS(1), .FIFO_DEPTH(16)) u_dut_b (
    .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data_b), .pi_flag(pi_flag_b),
    .po_data(po_data_b), .po_valid(po_valid_b), .po_ready(po_ready_b),
    .po_last(po_last_b), .frame_done(frame_done_b), .overflow(overflow_b));

  edge_packer #(.COLS(318), .ROWS(4), .FIFO_DEPTH(16)) u_dut_c (
    .sclk(sclk), .rst_n(rst_n), .pi_data(pi_data_c), .pi_flag(pi_flag_c),
    .po_data(po_data_c), .po_valid(po_valid_c), .po_ready(po_ready_c),
    .po_last(po_last_c), .frame_done(frame_done_c), .overflow(overflow_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [8:0] obs,
                     input logic fd);
    logic [8:0] e;
    bit         have;
    if (!rst_n) begin
      stall_prev[d] = 1'b0;
      return;
    end
    if (fd === 1'b1) fd_cnt[d]++;
    if (stall_prev[d] && v === 1'b1)
      check($sformatf("stall_stable_dut%0d", d), 32'(obs), 32'(stall_val[d]));
    if (v === 1'b1 && r === 1'b1) begin
      have = 1'b0;
      e    = 9'h000;
      case (d)
        0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        2: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
        default: ;
      endcase
      if (!have) begin
        n_cmp++;
        n_fail++;
        $error("FAIL unexpected_byte_dut%0d: observed %0h expected none", d, obs);
      end else begin
        check($sformatf("byte_dut%0d_n%0d", d, n_out[d]), 32'(obs), 32'(e));
      end
      n_out[d]++;
      stall_prev[d] = 1'b0;
    end else if (v === 1'b1) begin
      stall_prev[d] = 1'b1;
      stall_val[d]  = obs;
    end else begin
      stall_prev[d] = 1'b0;
    end
  endtask

  always @(negedge sclk) begin
    mon(0, po_valid_a, po_ready_a, {po_last_a, po_data_a}, frame_done_a);
    mon(1, po_valid_b, po_ready_b, {po_last_b, po_data_b}, frame_done_b);
    mon(2, po_valid_c, po_ready_c, {po_last_c, po_data_c}, frame_done_c);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  // Drives one pixel strobe and advances the reference packer; keep=0 marks a byte the DUT must drop.
  task automatic send_pixel(input int d, input logic [7:0] px, input bit keep);
    bit         col_end;
    logic [8:0] ent;
    case (d)
      0: begin pi_data_a = px; pi_flag_a = 1'b1; end
      1: begin pi_data_b = px; pi_flag_b = 1'b1; end
      2: begin pi_data_c = px; pi_flag_c = 1'b1; end
      default: ;
    endcase
    col_end = (m_col[d] == cols_of[d] - 1);
    m_sh[d][7 - m_bit[d]] = ~px[7];
    if (m_bit[d] == 7 || col_end) begin
      ent = {col_end && (m_row[d] == rows_of[d] - 1), m_sh[d]};
      if (keep) begin
        case (d)
          0: q0.push_back(ent);
          1: q1.push_back(ent);
          2: q2.push_back(ent);
          default: ;
        endcase
      end
      m_sh[d]  = 8'h00;
      m_bit[d] = 0;
    end else begin
      m_bit[d]++;
    end
    if (col_end) begin
      m_col[d] = 0;
      m_row[d] = (m_row[d] == rows_of[d] - 1) ? 0 : m_row[d] + 1;
    end else begin
      m_col[d]++;
    end
    tick(1);
    pi_flag_a = 1'b0;
    pi_flag_b = 1'b0;
    pi_flag_c = 1'b0;
  endtask

  // Eight pixels whose packed value is val (edge pixel 0 for a 1 bit).
  task automatic send_byte(input int d, input logic [7:0] val, input bit keep);
    for (int i = 0; i < 8; i++)
      send_pixel(d, val[7 - i] ? 8'h00 : 8'hFF, keep);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pi_flag_a = 1'b0;
    pi_flag_b = 1'b0;
    pi_flag_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_col[i] = 0; m_row[i] = 0; m_bit[i] = 0; m_sh[i] = 8'h00;
      fd_cnt[i] = 0; n_out[i] = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    int         gap;
    pi_data_a = 8'h00; pi_data_b = 8'h00; pi_data_c = 8'h00;
    pi_flag_a = 1'b0;  pi_flag_b = 1'b0;  pi_flag_c = 1'b0;
    po_ready_a = 1'b0; po_ready_b = 1'b0; po_ready_c = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_col[i] = 0; m_row[i] = 0; m_bit[i] = 0; m_sh[i] = 8'h00;
      fd_cnt[i] = 0; n_out[i] = 0; stall_prev[i] = 1'b0; stall_val[i] = 9'h000;
    end

    // Reset values, sampled while rst_n is held low.
    tick(2);
    check("rst_po_data",    32'(po_data_a),    32'h0);
    check("rst_po_valid",   32'(po_valid_a),   32'h0);
    check("rst_po_last",    32'(po_last_a),    32'h0);
    check("rst_frame_done", 32'(frame_done_a), 32'h0);
    check("rst_overflow",   32'(overflow_a),   32'h0);
    check("rst_po_valid_c", 32'(po_valid_c),   32'h0);
    do_reset();

    // 16x2 frame of alternating edge/background: four 0xAA bytes, last on the fourth.
    po_ready_a = 1'b1;
    for (int i = 0; i < 32; i++)
      send_pixel(0, (i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1);
    tick(8);
    check("alt_bytes_out",  32'(n_out[0]),   32'd4);
    check("alt_queue_left", 32'(q0.size()),  32'd0);
    check("alt_frame_done", 32'(fd_cnt[0]),  32'd1);

    // 10-pixel row: 0xFF then padded 0xC0 with po_last; two-cycle latency on the first byte.
    po_ready_b = 1'b1;
    for (int i = 0; i < 8; i++)
      send_pixel(1, 8'h00, 1'b1);
    check("lat_valid_early", 32'(po_valid_b), 32'h0);
    tick(1);
    check("lat_valid_rise",  32'(po_valid_b), 32'h1);
    check("lat_first_data",  32'(po_data_b),  32'hFF);
    send_pixel(1, 8'h00, 1'b1);
    send_pixel(1, 8'h00, 1'b1);
    tick(6);
    check("pad_bytes_out",  32'(n_out[1]),  32'd2);
    check("pad_queue_left", 32'(q1.size()), 32'd0);
    check("pad_frame_done", 32'(fd_cnt[1]), 32'd1);

    // Full FIFO: the completing strobe coincides with a pop, so the byte is kept.
    do_reset();
    po_ready_a = 1'b0;
    send_byte(0, 8'h81, 1'b1);
    send_byte(0, 8'h42, 1'b1);
    send_byte(0, 8'h24, 1'b1);
    send_byte(0, 8'h18, 1'b1);
    tick(4);
    check("fullpop_valid", 32'(po_valid_a), 32'h1);
    pat = 8'hCA;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) po_ready_a = 1'b1;
      send_pixel(0, pat[7 - i] ? 8'h00 : 8'hFF, 1'b1);
      po_ready_a = 1'b0;
    end
    check("fullpop_no_overflow", 32'(overflow_a), 32'h0);
    po_ready_a = 1'b1;
    tick(10);
    check("fullpop_bytes_out",  32'(n_out[0]),  32'd5);
    check("fullpop_queue_left", 32'(q0.size()), 32'd0);

    // Stalled sink, depth 4, six bytes offered: the fifth and sixth are dropped.
    do_reset();
    po_ready_a = 1'b0;
    send_byte(0, 8'h81, 1'b1);
    send_byte(0, 8'h42, 1'b1);
    send_byte(0, 8'h24, 1'b1);
    send_byte(0, 8'h18, 1'b1);
    check("ovf_before_5th", 32'(overflow_a), 32'h0);
    send_byte(0, 8'hF0, 1'b0);
    check("ovf_after_5th", 32'(overflow_a), 32'h1);
    send_byte(0, 8'h0F, 1'b0);
    check("ovf_head_data",  32'(po_data_a),  32'h81);
    check("ovf_head_valid", 32'(po_valid_a), 32'h1);
    po_ready_a = 1'b1;
    tick(10);
    check("ovf_bytes_out",  32'(n_out[0]),   32'd4);
    check("ovf_queue_left", 32'(q0.size()),  32'd0);
    check("ovf_sticky",     32'(overflow_a), 32'h1);
    check("ovf_frame_done", 32'(fd_cnt[0]),  32'd1);

    // Reset three pixels into a row; the next frame must carry no stale bits.
    do_reset();
    check("ovf_cleared_by_reset", 32'(overflow_a), 32'h0);
    po_ready_a = 1'b1;
    for (int i = 0; i < 3; i++)
      send_pixel(0, 8'h00, 1'b1);
    do_reset();
    check("midreset_no_output", 32'(po_valid_a), 32'h0);
    po_ready_a = 1'b1;
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h3C, 1'b1);
    send_byte(0, 8'h5A, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    tick(8);
    check("midreset_bytes_out",  32'(n_out[0]),  32'd4);
    check("midreset_queue_left", 32'(q0.size()), 32'd0);
    check("midreset_frame_done", 32'(fd_cnt[0]), 32'd1);

    // Default width, four rows, random pixels, random strobe gaps and random sink stalls.
    po_ready_c = 1'b1;
    for (int i = 0; i < 318 * 4; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        po_ready_c = ($urandom_range(0, 3) != 0);
        tick(1);
      end
      send_pixel(2, 8'($urandom), 1'b1);
    end
    po_ready_c = 1'b1;
    tick(40);
    check("rand_bytes_out",  32'(n_out[2]),   32'd160);
    check("rand_queue_left", 32'(q2.size()),  32'd0);
    check("rand_overflow",   32'(overflow_c), 32'h0);
    check("rand_frame_done", 32'(fd_cnt[2]),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
